stack_lifo_ctrl: RTL

//  Flop-based LIFO stack, 32 entries x 8 bits by default, with independent push
//  (writer) and pop (reader) valid/ready handshakes.
//  The write path stores bytes. The read path is the side that drains them:
//  it presents top-of-stack and consumes it on handshake.

---
 rtl/stack_pkg.sv | 8 +
 rtl/stack_mem.sv | 22 ++
 rtl/stack_lifo_ctrl.sv | 62 ++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared sizing for the byte LIFO stack and its data type.
package stack_pkg;
  localparam int DEPTH = 32;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef logic [WIDTH-1:0] data_t;
endpackage

// File: rtl/stack_mem.sv
// DEPTH x WIDTH flop storage: one synchronous write port, one async read port.
module stack_mem #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  // No reset: the controller masks stale contents whenever the stack is empty.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/stack_lifo_ctrl.sv
// LIFO controller: single occupancy count drives addressing, flags and handshakes.
module stack_lifo_ctrl #(
  parameter int DEPTH = stack_pkg::DEPTH,
  parameter int WIDTH = stack_pkg::WIDTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ready,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  input  logic             pop_ready,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  import stack_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic             push_fire;
  logic             pop_fire;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;

  assign empty      = (count == '0);
  assign full       = (count == CNT_W'(DEPTH));
  assign pop_valid  = ~empty;
  // A full stack still takes a push when the top is leaving in the same cycle.
  assign push_ready = ~full | pop_ready;
  assign push_fire  = push_valid & push_ready;
  assign pop_fire   = pop_valid & pop_ready;

  // Top lives at count-1; wraps harmlessly to DEPTH-1 when empty (output masked).
  assign raddr = count[AW-1:0] - AW'(1);
  // Simultaneous push+pop replaces the top rather than growing the stack.
  assign waddr = pop_fire ? raddr : count[AW-1:0];
  assign we    = push_fire & ~clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        count <= '0;
    else if (clear)                 count <= '0;
    else if (push_fire & ~pop_fire) count <= count + CNT_W'(1);
    else if (pop_fire & ~push_fire) count <= count - CNT_W'(1);
  end

  stack_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (push_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign pop_data = empty ? '0 : rdata;
endmodule
